// File: rtl/riv_up_counter.sv
// Loadable up-counter with terminal-count detect (done) and a registered arrival pulse (tick).
// Define RIV_UP_COUNTER_WRAP_EN to auto-reload to 0 at the target instead of saturating.
module riv_up_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             tick
);

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] target_next;
    logic             tick_next;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count + WIDTH'(1);

    // done compares live registers, so it is valid the same cycle count lands on target.
    assign done = (count == target);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next  = count;
        target_next = target;
        tick_next   = 1'b0;
        if (load) begin
            count_next  = '0;
            target_next = value;
        end else if (enable) begin
            if (!done) begin
                count_next = count_inc;
                tick_next  = (count_inc == target);
            end else begin
`ifdef RIV_UP_COUNTER_WRAP_EN
                // Reload to 0; with target 0 the step lands on target again.
                count_next = '0;
                tick_next  = (target == '0);
`else
                count_next = count;
                tick_next  = 1'b0;
`endif
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            target <= '0;
            tick   <= 1'b0;
        end else begin
            count  <= count_next;
            target <= target_next;
            tick   <= tick_next;
        end
    end

    // A tick can only be seen while count sits on the target it just reached.
    a_tick_implies_done : assert property (@(posedge clk) disable iff (!rst_n) tick |-> done);

    // count is cleared on load and reloads to 0 on wrap, so it never passes the target.
    a_count_bounded : assert property (@(posedge clk) disable iff (!rst_n) count <= target);

`ifndef RIV_UP_COUNTER_WRAP_EN
    a_saturate_holds : assert property (@(posedge clk) disable iff (!rst_n)
        (done && enable && !load) |=> ($stable(count) && !tick));
`endif

endmodule

// File: tb/tb_riv_up_counter.sv
// Scoreboard bench for riv_up_counter (WIDTH=4): stimulus pushes expected state, a monitor pops and compares.
// Honors RIV_UP_COUNTER_WRAP_EN in its reference model.
module tb_riv_up_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    typedef struct {
        int count;
        int done;
        int tick;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] value = '0;
    logic         load = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] count;
    logic         done;
    logic         tick;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];

    // Reference state: elapsed count since the last load, the latched target, and the pending pulse.
    int m_count  = 0;
    int m_target = 0;
    int m_tick   = 0;

    riv_up_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .load   (load),
        .enable (enable),
        .count  (count),
        .done   (done),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus, applied at the falling edge; the expected post-edge state is queued.
    task automatic cycle(input bit rst, input bit ld, input bit en, input int val);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        load   = ld;
        enable = en;
        value  = W'(val);
        if (!rst) begin
            m_count = 0; m_target = 0; m_tick = 0;
        end else if (ld) begin
            m_count = 0; m_target = val % MOD; m_tick = 0;
        end else if (!en) begin
            m_tick = 0;
        end else if (m_count < m_target) begin
            m_count = m_count + 1;
            m_tick  = (m_count == m_target) ? 1 : 0;
        end else begin
`ifdef RIV_UP_COUNTER_WRAP_EN
            m_count = 0;
            m_tick  = (m_target == 0) ? 1 : 0;
`else
            m_tick  = 0;
`endif
        end
        e.count = m_count;
        e.done  = (m_count == m_target) ? 1 : 0;
        e.tick  = m_tick;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the counter presents its state; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", int'(count), e.count);
                check("done", int'(done), e.done);
                check("tick", int'(tick), e.tick);
            end
        end
    end

    initial begin
        int budget;
        #1 rst_n = 1'b0;
        #1;
        check("reset_count", int'(count), 0);
        check("reset_done", int'(done), 1);
        check("reset_tick", int'(tick), 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // Async reset mid-count with no clock edge.
        cycle(1, 1, 0, 9);
        repeat (5) cycle(1, 0, 1, $urandom);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_count", int'(count), 0);
        check("midreset_done", int'(done), 1);
        check("midreset_tick", int'(tick), 0);
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);

        // Load 3, step three times, then one idle cycle.
        cycle(1, 1, 0, 3);
        repeat (3) cycle(1, 0, 1, $urandom);
        cycle(1, 0, 0, 0);

        // load beats enable.
        cycle(1, 1, 1, 7);
        cycle(1, 0, 0, 0);

        // Target 2 with enable held; saturates or wraps depending on build.
        cycle(1, 1, 0, 2);
        repeat (9) cycle(1, 0, 1, 0);

        // Target 0: load alone gives done without tick, then continuous enable.
        cycle(1, 1, 0, 0);
        repeat (4) cycle(1, 0, 1, 0);

        // Maximum target is reachable, then the behaviour at the top.
        cycle(1, 1, 0, MOD - 1);
        repeat (MOD - 1) cycle(1, 0, 1, 0);
        repeat (2) cycle(1, 0, 1, 0);

        // Randomized traffic, biased toward small targets so arrivals are frequent.
        for (int i = 0; i < 400; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MOD - 1)) : int'($urandom_range(0, 4));
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0), v);
        end
        cycle(1, 0, 0, 0);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
